// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES S-box tables, lookup helper, state width and FSM state type
// for the sub_bytes_engine datapath.
package aes_sbox_pkg;

   localparam int unsigned STATE_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   // FIPS-197 forward S-box, index = input byte
   localparam logic [7:0] FWD_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // FIPS-197 inverse S-box, index = input byte
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Mode-selected substitution of one byte: inv=0 forward, inv=1 inverse
   function automatic logic [7:0] sbox_lookup(input logic inv, input logic [7:0] data);
      return inv ? INV_SBOX[data] : FWD_SBOX[data];
   endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle for sub_bytes_engine: input state channel, result
// channel and the busy indicator. slave = engine side, master = driver side.
interface sub_bytes_engine_if
   import aes_sbox_pkg::*;
;
   logic                       in_valid;
   logic                       in_ready;
   logic [STATE_BYTES*8-1:0]   in_data;
   logic                       in_inv;
   logic                       out_valid;
   logic                       out_ready;
   logic [STATE_BYTES*8-1:0]   out_data;
   logic                       out_inv;
   logic                       busy;

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data, out_inv, busy
   );

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data, out_inv, busy
   );

endinterface

// File: rtl/aes_sbox_lane.sv
// One S-box lane: substitutes a single byte in the selected direction.
module aes_sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic       inv,
   input  logic [7:0] data,
   output logic [7:0] result
);

   // table lookup, purely combinational
   always_comb begin
      result = sbox_lookup(inv, data);
   end

endmodule

// File: rtl/sub_bytes_engine.sv
// Handshaked AES SubBytes / InvSubBytes unit. The 128-bit state is held in
// a working buffer and substituted LANES bytes per cycle, chunk by chunk,
// so 16/LANES cycles are spent in BUSY per transaction.
module sub_bytes_engine
   import aes_sbox_pkg::*;
#(
   parameter int unsigned LANES   = 4,
   parameter bit          OUT_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   sub_bytes_engine_if.slave bus
);

   localparam int unsigned N       = STATE_BYTES / LANES;
   localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CHUNK_W = LANES * 8;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t                   state_q;
   state_t                   state_d;
   logic [STATE_BYTES*8-1:0] buf_q;
   logic [STATE_BYTES*8-1:0] buf_upd;
   logic                     mode_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [CHUNK_W-1:0]       chunk_in;
   logic [CHUNK_W-1:0]       chunk_out;
   logic                     last_chunk;
   logic                     accept;
   logic                     in_ready_c;
   logic                     busy_c;

   assign last_chunk = (cnt_q == CNT_W'(N - 1));
   assign accept     = bus.in_valid && in_ready_c;
   assign chunk_in   = buf_q[32'(cnt_q) * CHUNK_W +: CHUNK_W];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_sbox_lane u_lane (
         .inv    (mode_q),
         .data   (chunk_in[8*l +: 8]),
         .result (chunk_out[8*l +: 8])
      );
   end

   // working buffer with the current chunk replaced by its substitution
   always_comb begin
      buf_upd = buf_q;
      buf_upd[32'(cnt_q) * CHUNK_W +: CHUNK_W] = chunk_out;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and handshake decode; DONE with out_ready and in_valid
   // goes straight back to BUSY so there is no idle bubble
   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      busy_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            busy_c = 1'b1;
            if (last_chunk) begin
               state_d = DONE;
            end
         end
         DONE: begin
            in_ready_c = bus.out_ready;
            if (bus.out_ready) begin
               state_d = bus.in_valid ? BUSY : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // capture on accept, then substitute one chunk per BUSY cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q  <= '0;
         mode_q <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         buf_q  <= bus.in_data;
         mode_q <= bus.in_inv;
         cnt_q  <= '0;
      end else if (state_q == BUSY) begin
         buf_q <= buf_upd;
         cnt_q <= last_chunk ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = (state_q == DONE);

   if (OUT_REG) begin : g_out_reg
      logic [STATE_BYTES*8-1:0] out_q;
      logic                     out_inv_q;

      // latch the fully substituted state on the edge that finishes chunk N-1
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q     <= '0;
            out_inv_q <= 1'b0;
         end else if (state_q == BUSY && last_chunk) begin
            out_q     <= buf_upd;
            out_inv_q <= mode_q;
         end
      end

      assign bus.out_data = out_q;
      assign bus.out_inv  = out_inv_q;
   end else begin : g_out_direct
      // buffer is only rewritten on accept or in BUSY, so it holds through DONE
      assign bus.out_data = buf_q;
      assign bus.out_inv  = mode_q;
   end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: three instances (LANES 1, 4, 16)
// checked against a GF(2^8) inverse + affine S-box model built at time zero.
module tb_sub_bytes_engine;

   localparam int unsigned LANES_CFG  [3] = '{1, 4, 16};
   localparam bit          OUTREG_CFG [3] = '{1'b1, 1'b1, 1'b0};
   localparam int          N_CFG      [3] = '{16, 4, 1};

   logic         clk;
   logic         rst_n;
   logic         in_valid  [3];
   logic [127:0] in_data   [3];
   logic         in_inv    [3];
   logic         out_ready [3];
   logic [2:0]   in_ready_s;
   logic [2:0]   out_valid_s;
   logic [2:0]   out_inv_s;
   logic [2:0]   busy_s;
   logic [127:0] out_data_s [3];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] fwd_m [256];
   logic [7:0] inv_m [256];

   for (genvar d = 0; d < 3; d++) begin : g_dut
      sub_bytes_engine_if bus ();

      assign bus.in_valid   = in_valid[d];
      assign bus.in_data    = in_data[d];
      assign bus.in_inv     = in_inv[d];
      assign bus.out_ready  = out_ready[d];
      assign in_ready_s[d]  = bus.in_ready;
      assign out_valid_s[d] = bus.out_valid;
      assign out_inv_s[d]   = bus.out_inv;
      assign busy_s[d]      = bus.busy;
      assign out_data_s[d]  = bus.out_data;

      sub_bytes_engine #(
         .LANES   (LANES_CFG[d]),
         .OUT_REG (OUTREG_CFG[d])
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
      logic [7:0] a;
      logic [7:0] p;
      a = a_in;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
      logic [7:0] r;
      r = (x << k) | (x >> (8 - k));
      return r;
   endfunction

   function automatic logic [127:0] model(input logic inv, input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = inv ? inv_m[s[8*i +: 8]] : fwd_m[s[8*i +: 8]];
      end
      return r;
   endfunction

   // one complete transaction with random noise on the inputs while busy
   task automatic run_txn(input int d, input logic [127:0] data, input logic inv,
                          output logic [127:0] res, output logic res_inv,
                          output int lat, output int busy_n);
      check("in_ready_idle", 128'(in_ready_s[d]), 128'd1);
      in_valid[d]  = 1'b1;
      in_data[d]   = data;
      in_inv[d]    = inv;
      out_ready[d] = 1'b0;
      tick();
      lat    = 0;
      busy_n = 0;
      while (!out_valid_s[d] && lat < 40) begin
         if (busy_s[d]) busy_n++;
         in_valid[d]  = 1'($urandom);
         in_data[d]   = {$urandom, $urandom, $urandom, $urandom};
         in_inv[d]    = 1'($urandom);
         out_ready[d] = 1'($urandom);
         tick();
         lat++;
      end
      check("result_valid", 128'(out_valid_s[d]), 128'd1);
      res          = out_data_s[d];
      res_inv      = out_inv_s[d];
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      check("valid_drop", 128'(out_valid_s[d]), 128'd0);
   endtask

   initial begin
      logic [127:0] res, res2, exp, a, b;
      logic         ri, ia, ib;
      int           lat, busy_n, cnt;
      logic [7:0]   x, inv_x;

      // reference S-box: multiplicative inverse followed by the affine map
      for (int v = 0; v < 256; v++) begin
         x     = 8'(v);
         inv_x = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (v != 0 && gmul(x, 8'(y)) == 8'h01) inv_x = 8'(y);
         end
         fwd_m[v] = inv_x ^ rotl(inv_x, 1) ^ rotl(inv_x, 2) ^ rotl(inv_x, 3) ^ rotl(inv_x, 4) ^ 8'h63;
      end
      for (int v = 0; v < 256; v++) inv_m[fwd_m[v]] = 8'(v);

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         in_inv[d]    = 1'b0;
         out_ready[d] = 1'b0;
      end
      repeat (2) tick();
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", 128'(out_valid_s[d]), 128'd0);
         check("rst_out_data", out_data_s[d], 128'd0);
         check("rst_out_inv", 128'(out_inv_s[d]), 128'd0);
         check("rst_busy", 128'(busy_s[d]), 128'd0);
      end
      rst_n = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) check("rst_in_ready", 128'(in_ready_s[d]), 128'd1);

      // FIPS-197 example vector, forward, LANES=16
      run_txn(2, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, res, ri, lat, busy_n);
      check("vec_fwd_data", res, 128'hd42711aee0bf98f1b8b45de51e415230);
      check("vec_fwd_inv", 128'(ri), 128'd0);
      check("vec_fwd_lat", 128'(lat), 128'd1);

      // same vector back through the inverse, LANES=4
      run_txn(1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, res, ri, lat, busy_n);
      check("vec_inv_data", res, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      check("vec_inv_inv", 128'(ri), 128'd1);
      check("vec_inv_lat", 128'(lat), 128'd4);
      check("vec_inv_busy", 128'(busy_n), 128'd4);

      // exhaustive byte sweep on LANES=1, forward then inverse
      for (int v = 0; v < 256; v++) begin
         a = {16{8'(v)}};
         run_txn(0, a, 1'b0, res, ri, lat, busy_n);
         check("sweep_fwd", res, model(1'b0, a));
         check("sweep_fwd_lat", 128'(lat), 128'd16);
         run_txn(0, res, 1'b1, res2, ri, lat, busy_n);
         check("sweep_roundtrip", res2, a);
         check("sweep_inv_mode", 128'(ri), 128'd1);
         if (v == 8'h00) begin
            check("spot_fwd_00", res, {16{8'h63}});
            check("spot_inv_63", res2, {16{8'h00}});
         end
         if (v == 8'h53) check("spot_fwd_53", res, {16{8'hed}});
         if (v == 8'h52) begin
            check("spot_fwd_52", res, {16{8'h00}});
            check("spot_inv_00", res2, {16{8'h52}});
         end
      end

      // random states and modes on every instance
      for (int d = 0; d < 3; d++) begin
         for (int t = 0; t < 15; t++) begin
            a  = {$urandom, $urandom, $urandom, $urandom};
            ia = 1'($urandom);
            run_txn(d, a, ia, res, ri, lat, busy_n);
            check("rand_data", res, model(ia, a));
            check("rand_mode", 128'(ri), 128'(ia));
            check("rand_lat", 128'(lat), 128'(N_CFG[d]));
         end
      end

      // backpressure in DONE, then accept next state on the consuming edge
      a  = {$urandom, $urandom, $urandom, $urandom};
      ia = 1'b1;
      b  = {$urandom, $urandom, $urandom, $urandom};
      ib = 1'b0;
      exp = model(ia, a);
      in_valid[1] = 1'b1;
      in_data[1]  = a;
      in_inv[1]   = ia;
      out_ready[1] = 1'b0;
      tick();
      in_valid[1] = 1'b0;
      cnt = 0;
      while (!out_valid_s[1] && cnt < 40) begin
         tick();
         cnt++;
      end
      check("bp_lat", 128'(cnt), 128'd4);
      for (int c = 0; c < 10; c++) begin
         check("bp_valid", 128'(out_valid_s[1]), 128'd1);
         check("bp_data", out_data_s[1], exp);
         check("bp_mode", 128'(out_inv_s[1]), 128'(ia));
         check("bp_in_ready", 128'(in_ready_s[1]), 128'd0);
         in_data[1] = {$urandom, $urandom, $urandom, $urandom};
         in_inv[1]  = 1'($urandom);
         tick();
      end
      in_valid[1]  = 1'b1;
      in_data[1]   = b;
      in_inv[1]    = ib;
      out_ready[1] = 1'b1;
      #1;
      check("bp_in_ready_release", 128'(in_ready_s[1]), 128'd1);
      check("bp_data_release", out_data_s[1], exp);
      tick();
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b0;
      cnt = 0;
      while (!out_valid_s[1] && cnt < 40) begin
         check("bp_busy", 128'(busy_s[1]), 128'd1);
         tick();
         cnt++;
      end
      check("bp_next_lat", 128'(cnt), 128'd4);
      check("bp_next_data", out_data_s[1], model(ib, b));
      check("bp_next_mode", 128'(out_inv_s[1]), 128'(ib));
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;

      // asynchronous reset while LANES=4 is in BUSY with cnt=2
      a = {$urandom, $urandom, $urandom, $urandom};
      in_valid[1] = 1'b1;
      in_data[1]  = a;
      in_inv[1]   = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      repeat (2) tick();
      check("mid_busy", 128'(busy_s[1]), 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(out_valid_s[1]), 128'd0);
      check("mid_rst_data", out_data_s[1], 128'd0);
      check("mid_rst_inv", 128'(out_inv_s[1]), 128'd0);
      check("mid_rst_busy", 128'(busy_s[1]), 128'd0);
      #2;
      rst_n = 1'b1;
      #1;
      check("mid_rst_in_ready", 128'(in_ready_s[1]), 128'd1);
      a = {$urandom, $urandom, $urandom, $urandom};
      run_txn(1, a, 1'b0, res, ri, lat, busy_n);
      check("post_rst_data", res, model(1'b0, a));
      check("post_rst_lat", 128'(lat), 128'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
